// File: rtl/inst_mem_arbiter.sv
// Instruction SRAM port arbiter. The boot loader owns the port while boot
// mode is active. Otherwise CPU fetch and debug share it, and debug waits
// behind fetch for at most MAX_WAIT cycles. All SRAM controls are registered.
// Read ownership is tracked across the single-cycle SRAM read latency.
module inst_mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 20,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_boot_mode,
  input  logic                  i_boot_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_boot_addr,
  input  logic [DATA_WIDTH-1:0] i_boot_wr_data,
  input  logic                  i_fetch_req,
  input  logic [ADDR_WIDTH-1:0] i_fetch_addr,
  output logic                  o_fetch_gnt,
  output logic                  o_fetch_rd_valid,
  output logic [DATA_WIDTH-1:0] o_fetch_rd_data,
  input  logic                  i_dbg_req,
  input  logic                  i_dbg_we,
  input  logic [ADDR_WIDTH-1:0] i_dbg_addr,
  input  logic [DATA_WIDTH-1:0] i_dbg_wr_data,
  output logic                  o_dbg_gnt,
  output logic                  o_dbg_rd_valid,
  output logic [DATA_WIDTH-1:0] o_dbg_rd_data,
  output logic                  o_mem_en,
  output logic                  o_mem_wr_en,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wr_data,
  input  logic [DATA_WIDTH-1:0] i_mem_rd_data,
  output logic                  o_cpu_stall
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_fetch_gnt;
  logic                  w_dbg_gnt;
  logic                  w_cpu_stall;

  logic [WAIT_W-1:0]     r_wait_cnt;

  logic                  r_mem_en;
  logic                  r_mem_wr_en;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wr_data;

  // Owner of the read currently presented to the SRAM (mem_en cycle)
  logic                  r_iss_fetch;
  logic                  r_iss_dbg;
  logic                  r_fetch_rd_valid;
  logic                  r_dbg_rd_valid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, grants and CPU stall, all from current inputs and state
  always_comb begin
    w_state_nxt = r_state;
    w_fetch_gnt = 1'b0;
    w_dbg_gnt   = 1'b0;
    case (r_state)
      ST_BOOT: begin
        if (!i_boot_mode) w_state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        // The last boot write is on the SRAM port during this cycle
        w_state_nxt = i_boot_mode ? ST_BOOT : ST_RUN;
      end
      ST_RUN: begin
        // Fetch has priority until debug has waited MAX_WAIT cycles
        w_dbg_gnt   = i_dbg_req && (!i_fetch_req || (r_wait_cnt == WAIT_MAX));
        w_fetch_gnt = i_fetch_req && !w_dbg_gnt;
        if (i_boot_mode) w_state_nxt = ST_BOOT;
      end
      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
    w_cpu_stall = (r_state != ST_RUN) || (i_fetch_req && !w_fetch_gnt);
  end

  // Debug starvation counter, live only in RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if ((r_state == ST_RUN) && i_dbg_req && !w_dbg_gnt) begin
      if (r_wait_cnt != WAIT_MAX) r_wait_cnt <= r_wait_cnt + 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // Registered SRAM controls; address and data hold when the port is idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_en      <= 1'b0;
      r_mem_wr_en   <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wr_data <= '0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_mem_en      <= i_boot_wr_en;
          r_mem_wr_en   <= i_boot_wr_en;
          r_mem_addr    <= i_boot_addr;
          r_mem_wr_data <= i_boot_wr_data;
        end
        ST_RUN: begin
          if (w_fetch_gnt) begin
            r_mem_en    <= 1'b1;
            r_mem_wr_en <= 1'b0;
            r_mem_addr  <= i_fetch_addr;
          end else if (w_dbg_gnt) begin
            r_mem_en      <= 1'b1;
            r_mem_wr_en   <= i_dbg_we;
            r_mem_addr    <= i_dbg_addr;
            r_mem_wr_data <= i_dbg_wr_data;
          end else begin
            r_mem_en    <= 1'b0;
            r_mem_wr_en <= 1'b0;
          end
        end
        default: begin
          r_mem_en    <= 1'b0;
          r_mem_wr_en <= 1'b0;
        end
      endcase
    end
  end

  // Read owner tracking: tag at accept, valid one cycle after mem_en
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iss_fetch      <= 1'b0;
      r_iss_dbg        <= 1'b0;
      r_fetch_rd_valid <= 1'b0;
      r_dbg_rd_valid   <= 1'b0;
    end else begin
      r_iss_fetch      <= w_fetch_gnt;
      r_iss_dbg        <= w_dbg_gnt && !i_dbg_we;
      r_fetch_rd_valid <= r_iss_fetch;
      r_dbg_rd_valid   <= r_iss_dbg;
    end
  end

  assign o_fetch_gnt      = w_fetch_gnt;
  assign o_dbg_gnt        = w_dbg_gnt;
  assign o_cpu_stall      = w_cpu_stall;
  assign o_mem_en         = r_mem_en;
  assign o_mem_wr_en      = r_mem_wr_en;
  assign o_mem_addr       = r_mem_addr;
  assign o_mem_wr_data    = r_mem_wr_data;
  assign o_fetch_rd_valid = r_fetch_rd_valid;
  assign o_dbg_rd_valid   = r_dbg_rd_valid;
  assign o_fetch_rd_data  = i_mem_rd_data;
  assign o_dbg_rd_data    = i_mem_rd_data;

endmodule

// File: tb/tb_inst_mem_arbiter.sv
// Bench for inst_mem_arbiter: directed scenarios followed by random traffic,
// checked every cycle against a transaction-level reference model.
module tb_inst_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 20;
  localparam int MW = 4;

  localparam int M_BOOT   = 0;
  localparam int M_SETTLE = 1;
  localparam int M_RUN    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          boot_mode, boot_wr_en;
  logic [AW-1:0] boot_addr;
  logic [DW-1:0] boot_wr_data;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_gnt, fetch_rd_valid;
  logic [DW-1:0] fetch_rd_data;
  logic          dbg_req, dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wr_data;
  logic          dbg_gnt, dbg_rd_valid;
  logic [DW-1:0] dbg_rd_data;
  logic          mem_en, mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data;
  logic          cpu_stall;

  always #5 clk = ~clk;

  inst_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_boot_mode(boot_mode), .i_boot_wr_en(boot_wr_en),
    .i_boot_addr(boot_addr), .i_boot_wr_data(boot_wr_data),
    .i_fetch_req(fetch_req), .i_fetch_addr(fetch_addr),
    .o_fetch_gnt(fetch_gnt), .o_fetch_rd_valid(fetch_rd_valid),
    .o_fetch_rd_data(fetch_rd_data),
    .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr),
    .i_dbg_wr_data(dbg_wr_data), .o_dbg_gnt(dbg_gnt),
    .o_dbg_rd_valid(dbg_rd_valid), .o_dbg_rd_data(dbg_rd_data),
    .o_mem_en(mem_en), .o_mem_wr_en(mem_wr_en), .o_mem_addr(mem_addr),
    .o_mem_wr_data(mem_wr_data), .i_mem_rd_data(mem_rd_data),
    .o_cpu_stall(cpu_stall)
  );

  // Behavioural SRAM: 16 words, one-cycle read latency
  bit   [DW-1:0] sram [16];
  logic [DW-1:0] rdq = '0;
  assign mem_rd_data = rdq;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wr_en) sram[mem_addr[5:2]] <= mem_wr_data;
      else           rdq <= sram[mem_addr[5:2]];
    end
  end

  // Reference model state
  int            mode;
  int            m_wait;
  logic          m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            iss_own;   // 0 none, 1 fetch, 2 debug: read on the bus now
  int            vld_own;   // read whose data is returned now
  logic [DW-1:0] vld_data;
  bit   [DW-1:0] gold [16];
  bit            acc_f, acc_d;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic bit exp_dg();
    return (mode == M_RUN) && dbg_req && (!fetch_req || (m_wait == MW));
  endfunction

  function automatic bit exp_fg();
    return (mode == M_RUN) && fetch_req && !exp_dg();
  endfunction

  task automatic model_reset();
    mode = M_BOOT; m_wait = 0; m_en = 0; m_we = 0; m_addr = '0; m_data = '0;
    iss_own = 0; vld_own = 0; vld_data = '0; acc_f = 0; acc_d = 0;
  endtask

  // Advance the model across one active clock edge
  task automatic model_edge();
    bit fg, dg;
    if (!rst_n) begin
      model_reset();
      return;
    end
    vld_own = iss_own;
    if (m_en && !m_we) vld_data = gold[m_addr[5:2]];
    if (m_en && m_we) gold[m_addr[5:2]] = m_data;
    fg = exp_fg();
    dg = exp_dg();
    acc_f = fg;
    acc_d = dg;
    iss_own = 0;
    if (mode == M_BOOT) begin
      m_en = boot_wr_en; m_we = boot_wr_en; m_addr = boot_addr; m_data = boot_wr_data;
    end else if (mode == M_RUN && fg) begin
      m_en = 1; m_we = 0; m_addr = fetch_addr; iss_own = 1;
    end else if (mode == M_RUN && dg) begin
      m_en = 1; m_we = dbg_we; m_addr = dbg_addr; m_data = dbg_wr_data;
      iss_own = dbg_we ? 0 : 2;
    end else begin
      m_en = 0; m_we = 0;
    end
    if (mode == M_RUN && dbg_req && !dg) m_wait = (m_wait < MW) ? m_wait + 1 : MW;
    else m_wait = 0;
    case (mode)
      M_BOOT:   mode = boot_mode ? M_BOOT : M_SETTLE;
      M_SETTLE: mode = boot_mode ? M_BOOT : M_RUN;
      default:  mode = boot_mode ? M_BOOT : M_RUN;
    endcase
  endtask

  task automatic check_now();
    chk("fetch_gnt", fetch_gnt, exp_fg());
    chk("dbg_gnt", dbg_gnt, exp_dg());
    chk("cpu_stall", cpu_stall, (mode != M_RUN) || (fetch_req && !exp_fg()));
    chk("mem_en", mem_en, m_en);
    chk("mem_wr_en", mem_wr_en, m_we);
    chk("mem_addr", mem_addr, m_addr);
    if (m_we) chk("mem_wr_data", mem_wr_data, m_data);
    chk("fetch_rd_valid", fetch_rd_valid, vld_own == 1);
    chk("dbg_rd_valid", dbg_rd_valid, vld_own == 2);
    if (vld_own == 1) chk("fetch_rd_data", fetch_rd_data, vld_data);
    if (vld_own == 2) chk("dbg_rd_data", dbg_rd_data, vld_data);
    chk("wait_cnt", 64'(dut.r_wait_cnt), 64'(m_wait));
  endtask

  task automatic cycle();
    @(negedge clk);
    check_now();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic fetch_acc(input logic [AW-1:0] a);
    bit ok = 0;
    fetch_req = 1; fetch_addr = a;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (acc_f) begin ok = 1; break; end
    end
    fetch_req = 0;
    chk("fetch_accept_timeout", ok, 1);
  endtask

  task automatic dbg_acc(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit ok = 0;
    dbg_req = 1; dbg_we = we; dbg_addr = a; dbg_wr_data = d;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (acc_d) begin ok = 1; break; end
    end
    dbg_req = 0;
    chk("dbg_accept_timeout", ok, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int dbg_cyc;
    boot_mode = 1; boot_wr_en = 0; boot_addr = '0; boot_wr_data = '0;
    fetch_req = 0; fetch_addr = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wr_data = '0;
    model_reset();

    // Reset state
    #2;
    check_now();
    chk("reset_mem_wr_data", mem_wr_data, 0);
    cycle(); cycle();
    rst_n = 1;

    // Boot writes
    for (int i = 0; i < 3; i++) begin
      boot_wr_en = 1; boot_addr = AW'(i * 4); boot_wr_data = DW'(32'hA0 + i);
      cycle();
      boot_wr_en = 0;
      cycle();
    end

    // Leave boot, first fetch of 0x004 returns 0xA1
    boot_mode = 0;
    fetch_acc(AW'(4));
    cycle();
    chk("first_fetch_valid", fetch_rd_valid, 1);
    chk("first_fetch_data", fetch_rd_data, 32'hA1);
    cycle(); cycle();

    // Fetch streaming with debug read pending from cycle 0
    fetch_req = 1; fetch_addr = '0;
    dbg_req = 1; dbg_we = 0; dbg_addr = AW'(8);
    dbg_cyc = -1;
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (acc_f) fetch_addr = fetch_addr + AW'(4);
      if (acc_d) begin dbg_req = 0; dbg_cyc = c; end
    end
    fetch_req = 0;
    chk("dbg_starve_cycle", dbg_cyc, MW);
    cycle(); cycle();
    chk("wait_cnt_cleared", 64'(dut.r_wait_cnt), 0);

    // Debug write then read back
    dbg_acc(1, AW'(16), DW'(32'hDEAD));
    dbg_acc(0, AW'(16), '0);
    cycle();
    chk("dbg_read_valid", dbg_rd_valid, 1);
    chk("dbg_read_data", dbg_rd_data, 32'hDEAD);
    cycle();

    // Boot mode rises right after a fetch accept; the read still returns
    fetch_acc(AW'(8));
    boot_mode = 1;
    cycle();
    chk("boot_rise_fetch_valid", fetch_rd_valid, 1);
    chk("boot_rise_fetch_data", fetch_rd_data, 32'hA2);
    fetch_req = 1; fetch_addr = AW'(12);
    cycle(); cycle();
    chk("boot_fetch_gnt", fetch_gnt, 0);
    chk("boot_cpu_stall", cpu_stall, 1);
    fetch_req = 0;
    boot_mode = 0;
    cycle(); cycle(); cycle();

    // Reset the cycle after a fetch accept
    fetch_acc(AW'(4));
    rst_n = 0;
    #1;
    model_reset();
    check_now();
    chk("midreset_mem_wr_data", mem_wr_data, 0);
    cycle(); cycle();
    boot_mode = 1;
    rst_n = 1;
    cycle(); cycle(); cycle();
    chk("midreset_no_valid", fetch_rd_valid, 0);

    // Random traffic
    boot_mode = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 59) == 0) boot_mode = ~boot_mode;
      boot_wr_en = boot_mode && ($urandom_range(0, 1) == 1);
      boot_addr = AW'($urandom_range(0, 15) * 4);
      boot_wr_data = $urandom;
      if (!fetch_req || acc_f) begin
        fetch_req = ($urandom_range(0, 2) != 0);
        fetch_addr = AW'($urandom_range(0, 15) * 4);
      end
      if (!dbg_req || acc_d) begin
        dbg_req = ($urandom_range(0, 3) == 0);
        dbg_we = ($urandom_range(0, 1) == 1);
        dbg_addr = AW'($urandom_range(0, 15) * 4);
        dbg_wr_data = $urandom;
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
